// File: rtl/control_unit_types_pkg.sv
// Control-unit decode types carried down the pipeline.
package control_unit_types_pkg;
    typedef enum logic [1:0] {
        MTR_ALU  = 2'd0,
        MTR_LOAD = 2'd1,
        MTR_NPC  = 2'd2,
        MTR_LUI  = 2'd3
    } memtoreg_t;

    // Primary opcode and R-type function field as decoded in ID.
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] func;
    } opfunc_t;
endpackage : control_unit_types_pkg

// File: rtl/cpu_types_pkg.sv
// Datapath word and register-index types shared across the MIPS core.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;
endpackage : cpu_types_pkg

// File: rtl/mmwb_stage_wb_mux.sv
// Writeback value select and register-file write-enable gating for the WB stage.
module mmwb_stage_wb_mux
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
(
    input  logic      wb_valid,
    input  logic      wb_RegWEN,
    input  regbits_t  wb_rd,
    input  logic      halt,
    input  memtoreg_t wb_MemtoReg,
    input  word_t     wb_ALUOut,
    input  word_t     wb_load,
    input  word_t     wb_npc,
    input  logic [15:0] wb_imm,
    output logic      rf_WEN,
    output word_t     rf_wdat
);

    // Writes to $zero are suppressed here so forwarding never advertises r0.
    assign rf_WEN = wb_valid & wb_RegWEN & (wb_rd != '0) & ~halt;

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        rf_wdat = wb_ALUOut;
        case (wb_MemtoReg)
            MTR_ALU:  rf_wdat = wb_ALUOut;
            MTR_LOAD: rf_wdat = wb_load;
            MTR_NPC:  rf_wdat = wb_npc;
            MTR_LUI:  rf_wdat = {wb_imm, 16'h0000};
            default:  rf_wdat = wb_ALUOut;
        endcase
    end

endmodule : mmwb_stage_wb_mux

// File: rtl/mmwb_stage.sv
// MEM/WB pipeline register with writeback select, forwarding, sticky halt and retire counter.
module mmwb_stage
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             mm_valid,
    input  opfunc_t          mm_opfunc,
    input  memtoreg_t        mm_MemtoReg,
    input  logic             mm_RegWEN,
    input  logic             mm_equal,
    input  logic             mm_halt,
    input  regbits_t         mm_rd,
    input  word_t            mm_portB,
    input  word_t            mm_npc,
    input  word_t            mm_ALUOut,
    input  word_t            mm_load,
    output opfunc_t          wb_opfunc,
    output memtoreg_t        wb_MemtoReg,
    output logic             wb_RegWEN,
    output logic             wb_equal,
    output logic             wb_halt,
    output regbits_t         wb_rd,
    output word_t            wb_portB,
    output word_t            wb_npc,
    output word_t            wb_ALUOut,
    output word_t            wb_load,
    output logic             rf_WEN,
    output regbits_t         rf_wsel,
    output word_t            rf_wdat,
    output logic             fwd_valid,
    output regbits_t         fwd_rd,
    output word_t            fwd_data,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    logic wb_valid;

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            wb_valid    <= 1'b0;
            wb_opfunc   <= '0;
            wb_MemtoReg <= MTR_ALU;
            wb_RegWEN   <= 1'b0;
            wb_equal    <= 1'b0;
            wb_halt     <= 1'b0;
            wb_rd       <= '0;
            wb_portB    <= '0;
            wb_npc      <= '0;
            wb_ALUOut   <= '0;
            wb_load     <= '0;
            halt        <= 1'b0;
            retired     <= '0;
        end else if (!halt) begin
            if (flush) begin
                // Bubble: only the control bits matter, data fields keep stale values.
                wb_valid  <= 1'b0;
                wb_RegWEN <= 1'b0;
                wb_halt   <= 1'b0;
            end else if (en) begin
                wb_valid    <= mm_valid;
                wb_opfunc   <= mm_opfunc;
                wb_MemtoReg <= mm_MemtoReg;
                wb_RegWEN   <= mm_RegWEN;
                wb_equal    <= mm_equal;
                wb_halt     <= mm_halt & mm_valid;
                wb_rd       <= mm_rd;
                wb_portB    <= mm_portB;
                wb_npc      <= mm_npc;
                wb_ALUOut   <= mm_ALUOut;
                wb_load     <= mm_load;
                halt        <= mm_halt & mm_valid;
                if (mm_valid) begin
                    retired <= retired + CNT_W'(1);
                end
            end
        end
    end

    mmwb_stage_wb_mux u_wb_mux (
        .wb_valid    (wb_valid),
        .wb_RegWEN   (wb_RegWEN),
        .wb_rd       (wb_rd),
        .halt        (halt),
        .wb_MemtoReg (wb_MemtoReg),
        .wb_ALUOut   (wb_ALUOut),
        .wb_load     (wb_load),
        .wb_npc      (wb_npc),
        .wb_imm      (wb_portB[15:0]),
        .rf_WEN      (rf_WEN),
        .rf_wdat     (rf_wdat)
    );

    assign rf_wsel   = wb_rd;
    assign fwd_valid = rf_WEN;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = rf_wdat;

endmodule : mmwb_stage

// File: tb/tb_mmwb_stage.sv
// Self-checking bench for mmwb_stage: directed test-plan steps followed by randomized traffic.
module tb_mmwb_stage;
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST, en, flush;
    logic             mm_valid, mm_RegWEN, mm_equal, mm_halt;
    opfunc_t          mm_opfunc;
    memtoreg_t        mm_MemtoReg;
    regbits_t         mm_rd;
    word_t            mm_portB, mm_npc, mm_ALUOut, mm_load;
    opfunc_t          wb_opfunc;
    memtoreg_t        wb_MemtoReg;
    logic             wb_RegWEN, wb_equal, wb_halt;
    regbits_t         wb_rd;
    word_t            wb_portB, wb_npc, wb_ALUOut, wb_load;
    logic             rf_WEN, fwd_valid, halt;
    regbits_t         rf_wsel, fwd_rd;
    word_t            rf_wdat, fwd_data;
    logic [CNT_W-1:0] retired;

    always #5 CLK = ~CLK;

    mmwb_stage #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush),
        .mm_valid(mm_valid), .mm_opfunc(mm_opfunc), .mm_MemtoReg(mm_MemtoReg),
        .mm_RegWEN(mm_RegWEN), .mm_equal(mm_equal), .mm_halt(mm_halt), .mm_rd(mm_rd),
        .mm_portB(mm_portB), .mm_npc(mm_npc), .mm_ALUOut(mm_ALUOut), .mm_load(mm_load),
        .wb_opfunc(wb_opfunc), .wb_MemtoReg(wb_MemtoReg), .wb_RegWEN(wb_RegWEN),
        .wb_equal(wb_equal), .wb_halt(wb_halt), .wb_rd(wb_rd), .wb_portB(wb_portB),
        .wb_npc(wb_npc), .wb_ALUOut(wb_ALUOut), .wb_load(wb_load),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .halt(halt), .retired(retired)
    );

    // Reference model: what the WB slot holds, plus halt and a plain integer retire count.
    typedef struct {
        logic      valid;
        opfunc_t   opfunc;
        memtoreg_t mtr;
        logic      regwen;
        logic      equal;
        logic      is_halt;
        regbits_t  rd;
        word_t     portB, npc, alu, load;
    } slot_t;

    slot_t m;
    logic  m_halted;
    int    m_retired;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t exp_wdat();
        case (m.mtr)
            MTR_LOAD: return m.load;
            MTR_NPC:  return m.npc;
            MTR_LUI:  return m.portB * 32'd65536;
            default:  return m.alu;
        endcase
    endfunction

    function automatic logic exp_wen();
        return m.valid && m.regwen && (m.rd != 0) && !m_halted;
    endfunction

    task automatic model_edge();
        if (RST) begin
            m = '{valid: 1'b0, opfunc: '0, mtr: MTR_ALU, regwen: 1'b0, equal: 1'b0,
                  is_halt: 1'b0, rd: '0, portB: '0, npc: '0, alu: '0, load: '0};
            m_halted  = 1'b0;
            m_retired = 0;
        end else if (m_halted) begin
            // frozen
        end else if (flush) begin
            m.valid   = 1'b0;
            m.regwen  = 1'b0;
            m.is_halt = 1'b0;
        end else if (en) begin
            m = '{valid: mm_valid, opfunc: mm_opfunc, mtr: mm_MemtoReg, regwen: mm_RegWEN,
                  equal: mm_equal, is_halt: mm_valid && mm_halt, rd: mm_rd, portB: mm_portB,
                  npc: mm_npc, alu: mm_ALUOut, load: mm_load};
            if (mm_valid && mm_halt) m_halted = 1'b1;
            if (mm_valid) m_retired = (m_retired + 1) % (1 << CNT_W);
        end
    endtask

    task automatic check_all();
        check("rf_WEN",      64'(rf_WEN),      64'(exp_wen()));
        check("rf_wsel",     64'(rf_wsel),     64'(m.rd));
        check("rf_wdat",     64'(rf_wdat),     64'(exp_wdat()));
        check("fwd_valid",   64'(fwd_valid),   64'(exp_wen()));
        check("fwd_rd",      64'(fwd_rd),      64'(m.rd));
        check("fwd_data",    64'(fwd_data),    64'(exp_wdat()));
        check("halt",        64'(halt),        64'(m_halted));
        check("retired",     64'(retired),     64'(m_retired));
        check("wb_halt",     64'(wb_halt),     64'(m.is_halt));
        check("wb_RegWEN",   64'(wb_RegWEN),   64'(m.regwen));
        check("wb_rd",       64'(wb_rd),       64'(m.rd));
        check("wb_MemtoReg", 64'(wb_MemtoReg), 64'(m.mtr));
        check("wb_opfunc",   64'(wb_opfunc),   64'(m.opfunc));
        check("wb_equal",    64'(wb_equal),    64'(m.equal));
        check("wb_portB",    64'(wb_portB),    64'(m.portB));
        check("wb_npc",      64'(wb_npc),      64'(m.npc));
        check("wb_ALUOut",   64'(wb_ALUOut),   64'(m.alu));
        check("wb_load",     64'(wb_load),     64'(m.load));
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic rand_mm();
        mm_opfunc   = opfunc_t'(12'($urandom));
        mm_MemtoReg = memtoreg_t'(2'($urandom));
        mm_RegWEN   = 1'($urandom);
        mm_equal    = 1'($urandom);
        mm_rd       = regbits_t'($urandom);
        mm_portB    = $urandom;
        mm_npc      = $urandom;
        mm_ALUOut   = $urandom;
        mm_load     = $urandom;
    endtask

    // Random filler plus a valid, non-halt writer with the given destination and source.
    task automatic instr(input regbits_t rd, input memtoreg_t mtr);
        rand_mm();
        mm_valid    = 1'b1;
        mm_halt     = 1'b0;
        mm_RegWEN   = 1'b1;
        mm_rd       = rd;
        mm_MemtoReg = mtr;
        en          = 1'b1;
        flush       = 1'b0;
        RST         = 1'b0;
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; flush = 1'b0; mm_valid = 1'b0; mm_halt = 1'b0;
        rand_mm();
        m_halted = 1'b0; m_retired = 0;
        #2;

        // Reset
        tick();
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_rf_WEN",  64'(rf_WEN),  64'd0);

        // ALU write
        instr(5'd8, MTR_ALU); mm_ALUOut = 32'h0000_1234; tick();
        check("alu_wen",  64'(rf_WEN),  64'd1);
        check("alu_wsel", 64'(rf_wsel), 64'd8);
        check("alu_wdat", 64'(rf_wdat), 64'h1234);
        check("alu_fwd",  64'(fwd_valid), 64'd1);
        check("alu_ret",  64'(retired), 64'd1);

        // Select paths
        instr(5'd5, MTR_LOAD); mm_load = 32'hDEAD_BEEF; tick();
        check("load_wdat", 64'(rf_wdat), 64'hDEAD_BEEF);
        instr(5'd31, MTR_NPC); mm_npc = 32'h0000_0040; tick();
        check("npc_wdat", 64'(rf_wdat), 64'h40);
        check("npc_wsel", 64'(rf_wsel), 64'd31);
        instr(5'd3, MTR_LUI); mm_portB = 32'h0000_ABCD; tick();
        check("lui_wdat", 64'(rf_wdat), 64'hABCD_0000);
        instr(5'd0, MTR_ALU); tick();
        check("r0_wen", 64'(rf_WEN), 64'd0);

        // Stall: held for two cycles while mm_* changes underneath
        instr(5'd9, MTR_ALU); mm_ALUOut = 32'h0000_0099; tick();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_mm(); mm_valid = 1'b1; tick();
        end
        check("stall_wen",  64'(rf_WEN),  64'd1);
        check("stall_wdat", 64'(rf_wdat), 64'h99);
        check("stall_ret",  64'(retired), 64'd6);

        // Flush wins over en
        instr(5'd10, MTR_ALU); flush = 1'b1; tick();
        check("flush_wen", 64'(rf_WEN),  64'd0);
        check("flush_ret", 64'(retired), 64'd6);

        // Halt ignored when invalid or flushed
        instr(5'd11, MTR_ALU); mm_valid = 1'b0; mm_halt = 1'b1; tick();
        check("halt_invalid", 64'(halt), 64'd0);
        instr(5'd11, MTR_ALU); mm_halt = 1'b1; flush = 1'b1; tick();
        check("halt_flushed", 64'(halt), 64'd0);

        // Valid HALT freezes everything
        instr(5'd4, MTR_ALU); mm_halt = 1'b1; tick();
        check("halt_set",  64'(halt),    64'd1);
        check("halt_ret",  64'(retired), 64'd7);
        check("halt_wen",  64'(rf_WEN),  64'd0);
        for (int i = 0; i < 3; i++) begin
            instr(5'd12, MTR_ALU); flush = 1'(i == 1); tick();
        end
        check("frozen_wen", 64'(rf_WEN),  64'd0);
        check("frozen_ret", 64'(retired), 64'd7);
        RST = 1'b1; tick(); RST = 1'b0;
        check("halt_clear", 64'(halt),    64'd0);
        check("halt_rst",   64'(retired), 64'd0);

        // Counter wrap after 2^CNT_W retirements
        for (int i = 0; i < (1 << CNT_W); i++) begin
            instr(regbits_t'(i + 1), MTR_ALU); tick();
            if (i == (1 << CNT_W) - 2) check("wrap_pre", 64'(retired), 64'd15);
        end
        check("wrap_zero", 64'(retired), 64'd0);

        // Randomized traffic, including occasional halts and resets
        for (int i = 0; i < 300; i++) begin
            rand_mm();
            mm_valid = ($urandom_range(0, 99) < 80);
            mm_halt  = ($urandom_range(0, 99) < 3);
            en       = ($urandom_range(0, 99) < 75);
            flush    = ($urandom_range(0, 99) < 15);
            RST      = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mmwb_stage
